// File: rtl/csa_accum_pkg.sv
// Shared constants and helpers for the carry-save accumulator.
// Holds the FSM state encoding, the accumulator width helper and the overflow limit.
package csa_accum_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE    = 2'd0;
   localparam state_t ACCUM   = 2'd1;
   localparam state_t RESOLVE = 2'd2;
   localparam state_t OUTPUT  = 2'd3;

   // Default guard width and the matching safe beat-count limit.
   localparam int unsigned GUARD_DEFAULT = 4;
   localparam int unsigned OVF_LIMIT     = 2 ** (GUARD_DEFAULT - 1);

   // Accumulator / result width: operand width plus guard bits.
   function automatic int unsigned acc_w(input int unsigned w, input int unsigned guard);
      return w + guard;
   endfunction

   // Safe beat-count limit for an arbitrary guard width.
   function automatic int unsigned ovf_limit(input int unsigned guard);
      return 32'd1 << (guard - 1);
   endfunction

endpackage

// File: rtl/compressor_4x2.sv
// Single-bit 4:2 compressor cell.
// x1+x2+x3+x4+cin = sum + 2*(carry+cout); cout depends only on x1..x3, so a row
// built from these cells has no ripple path through cin.
module compressor_4x2 (
   input  logic x1,
   input  logic x2,
   input  logic x3,
   input  logic x4,
   input  logic cin,
   output logic sum,
   output logic carry,
   output logic cout
);

   logic t;

   // First full-adder stage on x1..x3, second on the partial sum, x4 and cin.
   always_comb begin
      t     = x1 ^ x2 ^ x3;
      cout  = (x1 & x2) | (x1 & x3) | (x2 & x3);
      sum   = t ^ x4 ^ cin;
      carry = (t & x4) | (t & cin) | (x4 & cin);
   end

endmodule

// File: rtl/csa_row_4x2.sv
// One row of WIDTH 4:2 compressors reducing four vectors to a (sum, carry) pair.
// Purely combinational; the top slice's cout and carry are dropped (modulo 2^WIDTH).
module csa_row_4x2 #(
   parameter int unsigned WIDTH = 12
) (
   input  logic [WIDTH-1:0] x1,
   input  logic [WIDTH-1:0] x2,
   input  logic [WIDTH-1:0] x3,
   input  logic [WIDTH-1:0] x4,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] c
);

   logic [WIDTH-1:0] cin;
   logic [WIDTH-1:0] cout;
   logic [WIDTH-1:0] carry;
   logic             unused_top;

   // Slice i takes the cout of slice i-1; slice 0 gets a zero.
   assign cin = {cout[WIDTH-2:0], 1'b0};

   for (genvar i = 0; i < WIDTH; i++) begin : g_slice
      compressor_4x2 u_cell (
         .x1    (x1[i]),
         .x2    (x2[i]),
         .x3    (x3[i]),
         .x4    (x4[i]),
         .cin   (cin[i]),
         .sum   (s[i]),
         .carry (carry[i]),
         .cout  (cout[i])
      );
   end

   // carry[i] carries weight 2^(i+1), hence the shift.
   assign c = {carry[WIDTH-2:0], 1'b0};

   assign unused_top = cout[WIDTH-1] ^ carry[WIDTH-1];

endmodule

// File: rtl/csa_accum_ctrl.sv
// Sequential multi-operand carry-save accumulator with valid/ready handshakes.
// Two operands per beat are folded into a (S, C) state by one compressor row; the
// final sum is resolved with a single carry-propagate add.
// Build option: define SIGNED_OPS_EN to sign-extend operands (two's complement result);
// otherwise operands are zero-extended.
module csa_accum_ctrl
   import csa_accum_pkg::*;
#(
   parameter int unsigned W     = 8,
   parameter int unsigned GUARD = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [W-1:0]               in_a,
   input  logic [W-1:0]               in_b,
   input  logic                       in_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [acc_w(W, GUARD)-1:0] out_sum,
   output logic                       out_ovf
);

   localparam int unsigned     ACC_W   = acc_w(W, GUARD);
   localparam logic [GUARD-1:0] OVF_LIM = GUARD'(ovf_limit(GUARD));
   localparam logic [GUARD-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] s_q, s_d, c_q, c_d;
   logic [ACC_W-1:0] out_sum_q, out_sum_d;
   logic [GUARD-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic             out_ovf_q, out_ovf_d;

   logic [ACC_W-1:0] a_ext, b_ext;
   logic [ACC_W-1:0] row_x1, row_x2;
   logic [ACC_W-1:0] row_s, row_c;

`ifdef SIGNED_OPS_EN
   assign a_ext = {{GUARD{in_a[W-1]}}, in_a};
   assign b_ext = {{GUARD{in_b[W-1]}}, in_b};
`else
   assign a_ext = {{GUARD{1'b0}}, in_a};
   assign b_ext = {{GUARD{1'b0}}, in_b};
`endif

   // Ready depends on state only, never on in_valid.
   assign in_ready = (state_q == IDLE) || (state_q == ACCUM);

   // First beat of a packet compresses {0,0,a,b}; later beats fold in the held state.
   assign row_x1 = (state_q == ACCUM) ? s_q : '0;
   assign row_x2 = (state_q == ACCUM) ? c_q : '0;

   csa_row_4x2 #(
      .WIDTH (ACC_W)
   ) u_row (
      .x1 (row_x1),
      .x2 (row_x2),
      .x3 (a_ext),
      .x4 (b_ext),
      .s  (row_s),
      .c  (row_c)
   );

   // Next-state logic: FSM, carry-save state, beat counter and result registers.
   always_comb begin
      state_d     = state_q;
      s_d         = s_q;
      c_d         = c_q;
      cnt_d       = cnt_q;
      out_sum_d   = out_sum_q;
      out_valid_d = out_valid_q;
      out_ovf_d   = out_ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               s_d     = row_s;
               c_d     = row_c;
               cnt_d   = GUARD'(1);
               state_d = in_last ? RESOLVE : ACCUM;
            end
         end
         ACCUM: begin
            if (in_valid) begin
               s_d = row_s;
               c_d = row_c;
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + GUARD'(1);
               end
               if (in_last) begin
                  state_d = RESOLVE;
               end
            end
         end
         RESOLVE: begin
            out_sum_d   = s_q + c_q;
            out_ovf_d   = (cnt_q > OVF_LIM);
            out_valid_d = 1'b1;
            state_d     = OUTPUT;
         end
         OUTPUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               s_d         = '0;
               c_d         = '0;
               cnt_d       = '0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         s_q         <= '0;
         c_q         <= '0;
         cnt_q       <= '0;
         out_sum_q   <= '0;
         out_valid_q <= 1'b0;
         out_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         c_q         <= c_d;
         cnt_q       <= cnt_d;
         out_sum_q   <= out_sum_d;
         out_valid_q <= out_valid_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign out_sum   = out_sum_q;
   assign out_valid = out_valid_q;
   assign out_ovf   = out_ovf_q;

endmodule
